// File: rtl/trap_ctrl.sv
// Machine-mode trap controller: arbitrates exceptions/interrupts/mret, sequences CSR writes, redirects fetch.
// Optional TRAP_VECTORED_EN: vectored interrupt dispatch when mtvec mode is 01.
module trap_ctrl #(
  parameter int unsigned XLEN   = 64,
  parameter int unsigned INST_W = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] pc_i,
  input  logic [INST_W-1:0] inst_i,
  input  logic            jump_i,
  input  logic [XLEN-1:0] jump_pc_i,
  input  logic [3:0]      expt_info_i,
  input  logic [2:0]      irq_i,
  input  logic [XLEN-1:0] csr_mstatus_i,
  input  logic [XLEN-1:0] csr_mie_i,
  input  logic [XLEN-1:0] csr_mtvec_i,
  input  logic [XLEN-1:0] csr_mepc_i,
  output logic [XLEN-1:0] trap_addr_o,
  output logic            trap_valid_o,
  output logic            trap_hold_o,
  output logic            mepc_wen_o,
  output logic [XLEN-1:0] mepc_wdata_o,
  output logic            mcause_wen_o,
  output logic [XLEN-1:0] mcause_wdata_o,
  output logic            mtval_wen_o,
  output logic [XLEN-1:0] mtval_wdata_o,
  output logic            mstatus_wen_o,
  output logic [XLEN-1:0] mstatus_wdata_o
);

  typedef enum logic [1:0] {
    IDLE,
    TRAP,
    MRET
  } state_t;

  state_t state;

  logic [XLEN-1:0] cap_cause;
  logic [XLEN-1:0] cap_mepc;
  logic [XLEN-1:0] cap_mtval;

  logic            illegal, ecall, ebreak, mret;
  logic            int_mei, int_msi, int_mti;
  logic            evt_trap, evt_irq, evt_mret;
  logic [XLEN-1:0] evt_cause;
  logic            accept;
  logic [XLEN-1:0] mtvec_base;
  logic [XLEN-1:0] vec_addr;
  logic [XLEN-1:0] mstatus_trap;
  logic [XLEN-1:0] mstatus_mret;
  logic            unused_bits;

  assign {illegal, ecall, ebreak, mret} = expt_info_i;

  assign int_mei = csr_mstatus_i[3] & csr_mie_i[11] & irq_i[2];
  assign int_msi = csr_mstatus_i[3] & csr_mie_i[3]  & irq_i[1];
  assign int_mti = csr_mstatus_i[3] & csr_mie_i[7]  & irq_i[0];

  always_comb begin
    evt_trap  = 1'b1;
    evt_irq   = 1'b0;
    evt_cause = '0;
    if (illegal) begin
      evt_cause = XLEN'(2);
    end else if (ecall) begin
      evt_cause = XLEN'(11);
    end else if (ebreak) begin
      evt_cause = XLEN'(3);
    end else if (int_mei) begin
      evt_irq   = 1'b1;
      evt_cause = {1'b1, {(XLEN-5){1'b0}}, 4'd11};
    end else if (int_msi) begin
      evt_irq   = 1'b1;
      evt_cause = {1'b1, {(XLEN-5){1'b0}}, 4'd3};
    end else if (int_mti) begin
      evt_irq   = 1'b1;
      evt_cause = {1'b1, {(XLEN-5){1'b0}}, 4'd7};
    end else begin
      evt_trap  = 1'b0;
    end
  end

  assign evt_mret = mret & ~evt_trap;

  // The cycle the previous redirect is presented is not an arbitration slot,
  // which spaces successive traps at least three cycles apart.
  assign accept = (state == IDLE) & ~trap_valid_o;

  assign trap_hold_o = (state != IDLE) | evt_trap | mret;

  assign mtvec_base = {csr_mtvec_i[XLEN-1:2], 2'b00};

`ifdef TRAP_VECTORED_EN
  always_comb begin
    vec_addr = mtvec_base;
    if (cap_cause[XLEN-1] && (csr_mtvec_i[1:0] == 2'b01))
      vec_addr = mtvec_base + {{(XLEN-6){1'b0}}, cap_cause[3:0], 2'b00};
  end
`else
  assign vec_addr = mtvec_base;
`endif

  always_comb begin
    mstatus_trap        = csr_mstatus_i;
    mstatus_trap[7]     = csr_mstatus_i[3];
    mstatus_trap[3]     = 1'b0;
    mstatus_trap[12:11] = 2'b11;
  end

  always_comb begin
    mstatus_mret        = csr_mstatus_i;
    mstatus_mret[3]     = csr_mstatus_i[7];
    mstatus_mret[7]     = 1'b1;
    mstatus_mret[12:11] = 2'b11;
  end

  assign unused_bits = ^{csr_mie_i, csr_mtvec_i[1:0], cap_cause[XLEN-2:4]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      cap_cause       <= '0;
      cap_mepc        <= '0;
      cap_mtval       <= '0;
      trap_addr_o     <= '0;
      trap_valid_o    <= 1'b0;
      mepc_wen_o      <= 1'b0;
      mepc_wdata_o    <= '0;
      mcause_wen_o    <= 1'b0;
      mcause_wdata_o  <= '0;
      mtval_wen_o     <= 1'b0;
      mtval_wdata_o   <= '0;
      mstatus_wen_o   <= 1'b0;
      mstatus_wdata_o <= '0;
    end else begin
      trap_addr_o     <= '0;
      trap_valid_o    <= 1'b0;
      mepc_wen_o      <= 1'b0;
      mepc_wdata_o    <= '0;
      mcause_wen_o    <= 1'b0;
      mcause_wdata_o  <= '0;
      mtval_wen_o     <= 1'b0;
      mtval_wdata_o   <= '0;
      mstatus_wen_o   <= 1'b0;
      mstatus_wdata_o <= '0;
      case (state)
        IDLE: begin
          if (accept && evt_trap) begin
            state     <= TRAP;
            cap_cause <= evt_cause;
            cap_mepc  <= (evt_irq && jump_i) ? jump_pc_i : pc_i;
            cap_mtval <= illegal ? {{(XLEN-INST_W){1'b0}}, inst_i} : '0;
          end else if (accept && evt_mret) begin
            state <= MRET;
          end
        end
        TRAP: begin
          state           <= IDLE;
          trap_valid_o    <= 1'b1;
          trap_addr_o     <= vec_addr;
          mepc_wen_o      <= 1'b1;
          mepc_wdata_o    <= cap_mepc;
          mcause_wen_o    <= 1'b1;
          mcause_wdata_o  <= cap_cause;
          mtval_wen_o     <= 1'b1;
          mtval_wdata_o   <= cap_mtval;
          mstatus_wen_o   <= 1'b1;
          mstatus_wdata_o <= mstatus_trap;
        end
        MRET: begin
          state           <= IDLE;
          trap_valid_o    <= 1'b1;
          trap_addr_o     <= csr_mepc_i;
          mstatus_wen_o   <= 1'b1;
          mstatus_wdata_o <= mstatus_mret;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: priority, CSR write data, redirect address, spacing and reset abort.
module tb_trap_ctrl;
  localparam int unsigned XLEN   = 64;
  localparam int unsigned INST_W = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [XLEN-1:0]   pc_i, jump_pc_i;
  logic [INST_W-1:0] inst_i;
  logic              jump_i;
  logic [3:0]        expt_info_i;
  logic [2:0]        irq_i;
  logic [XLEN-1:0]   csr_mstatus_i, csr_mie_i, csr_mtvec_i, csr_mepc_i;
  logic [XLEN-1:0]   trap_addr_o;
  logic              trap_valid_o, trap_hold_o;
  logic              mepc_wen_o, mcause_wen_o, mtval_wen_o, mstatus_wen_o;
  logic [XLEN-1:0]   mepc_wdata_o, mcause_wdata_o, mtval_wdata_o, mstatus_wdata_o;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  trap_ctrl #(.XLEN(XLEN), .INST_W(INST_W)) dut (
    .clk(clk), .rst_n(rst_n), .pc_i(pc_i), .inst_i(inst_i), .jump_i(jump_i),
    .jump_pc_i(jump_pc_i), .expt_info_i(expt_info_i), .irq_i(irq_i),
    .csr_mstatus_i(csr_mstatus_i), .csr_mie_i(csr_mie_i), .csr_mtvec_i(csr_mtvec_i),
    .csr_mepc_i(csr_mepc_i), .trap_addr_o(trap_addr_o), .trap_valid_o(trap_valid_o),
    .trap_hold_o(trap_hold_o), .mepc_wen_o(mepc_wen_o), .mepc_wdata_o(mepc_wdata_o),
    .mcause_wen_o(mcause_wen_o), .mcause_wdata_o(mcause_wdata_o),
    .mtval_wen_o(mtval_wen_o), .mtval_wdata_o(mtval_wdata_o),
    .mstatus_wen_o(mstatus_wen_o), .mstatus_wdata_o(mstatus_wdata_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_events();
    expt_info_i = 4'b0;
    irq_i       = 3'b0;
    jump_i      = 1'b0;
  endtask

  // Event is sampled at the first edge, inputs are then withdrawn, outputs appear after the second.
  task automatic fire();
    step();
    clear_events();
    step();
  endtask

  task automatic check_all_wen(input string tag, input logic exp);
    check({tag, "_mepc_wen"},    XLEN'(mepc_wen_o),    XLEN'(exp));
    check({tag, "_mcause_wen"},  XLEN'(mcause_wen_o),  XLEN'(exp));
    check({tag, "_mtval_wen"},   XLEN'(mtval_wen_o),   XLEN'(exp));
    check({tag, "_mstatus_wen"}, XLEN'(mstatus_wen_o), XLEN'(exp));
  endtask

  logic [XLEN-1:0] exp_addr;

  initial begin
    rst_n = 1'b0;
    pc_i = '0; jump_pc_i = '0; inst_i = '0;
    clear_events();
    csr_mstatus_i = '0; csr_mie_i = '0; csr_mtvec_i = '0; csr_mepc_i = '0;
    repeat (2) step();
    rst_n = 1'b1;
    step();

    check("rst_valid", XLEN'(trap_valid_o), '0);
    check("rst_hold",  XLEN'(trap_hold_o),  '0);
    check("rst_addr",  trap_addr_o,         '0);
    check_all_wen("rst", 1'b0);

    // ecall, mode bits of mtvec must not leak into the address
    csr_mstatus_i = 64'h8;
    csr_mtvec_i   = 64'h8000_0001;
    pc_i          = 64'h8000_0010;
    expt_info_i   = 4'b0100;
    #1;
    check("ecall_hold_pending", XLEN'(trap_hold_o), 64'd1);
    step();
    clear_events();
    check("ecall_hold_trap", XLEN'(trap_hold_o), 64'd1);
    step();
    check("ecall_valid",   XLEN'(trap_valid_o), 64'd1);
    check_all_wen("ecall", 1'b1);
    check("ecall_mepc",    mepc_wdata_o,    64'h8000_0010);
    check("ecall_mcause",  mcause_wdata_o,  64'd11);
    check("ecall_mtval",   mtval_wdata_o,   64'd0);
    check("ecall_addr",    trap_addr_o,     64'h8000_0000);
    check("ecall_mstatus", mstatus_wdata_o, 64'h1880);
    step();
    check("ecall_valid_1cyc", XLEN'(trap_valid_o), 64'd0);
    check("ecall_wen_1cyc",   XLEN'(mepc_wen_o),   64'd0);

    // illegal with enabled mtip: exception wins
    csr_mie_i   = 64'h80;
    irq_i       = 3'b001;
    inst_i      = 32'hFFFF_FFFF;
    pc_i        = 64'h2000;
    expt_info_i = 4'b1000;
    fire();
    check("ill_mcause", mcause_wdata_o, 64'd2);
    check("ill_mtval",  mtval_wdata_o,  64'hFFFF_FFFF);
    check("ill_mepc",   mepc_wdata_o,   64'h2000);
    check("ill_addr",   trap_addr_o,    64'h8000_0000);
    step();

    // meip + mtip with a taken jump
    csr_mie_i = 64'h880;
    irq_i     = 3'b101;
    jump_i    = 1'b1;
    jump_pc_i = 64'h100;
    pc_i      = 64'h3000;
    fire();
    check("mei_mcause", mcause_wdata_o, 64'h8000_0000_0000_000B);
    check("mei_mepc",   mepc_wdata_o,   64'h100);
    check("mei_mtval",  mtval_wdata_o,  64'd0);
`ifdef TRAP_VECTORED_EN
    exp_addr = 64'h8000_002C;
`else
    exp_addr = 64'h8000_0000;
`endif
    check("mei_addr", trap_addr_o, exp_addr);
    step();

    // mtip alone, no jump
    csr_mie_i = 64'h80;
    irq_i     = 3'b001;
    pc_i      = 64'h4000;
    fire();
    check("mti_mcause", mcause_wdata_o, 64'h8000_0000_0000_0007);
    check("mti_mepc",   mepc_wdata_o,   64'h4000);
`ifdef TRAP_VECTORED_EN
    exp_addr = 64'h8000_001C;
`else
    exp_addr = 64'h8000_0000;
`endif
    check("mti_addr", trap_addr_o, exp_addr);
    step();

    // msip
    csr_mie_i = 64'h8;
    irq_i     = 3'b010;
    fire();
    check("msi_mcause", mcause_wdata_o, 64'h8000_0000_0000_0003);
    step();

    // ebreak
    expt_info_i = 4'b0010;
    fire();
    check("ebreak_mcause", mcause_wdata_o, 64'd3);
    step();

    // mret
    csr_mstatus_i = 64'h80;
    csr_mepc_i    = 64'h1234;
    expt_info_i   = 4'b0001;
    fire();
    check("mret_valid",       XLEN'(trap_valid_o),  64'd1);
    check("mret_mstatus_wen", XLEN'(mstatus_wen_o), 64'd1);
    check("mret_mstatus",     mstatus_wdata_o,      64'h1888);
    check("mret_addr",        trap_addr_o,          64'h1234);
    check("mret_mepc_wen",    XLEN'(mepc_wen_o),    64'd0);
    check("mret_mcause_wen",  XLEN'(mcause_wen_o),  64'd0);
    step();

    // global MIE clear masks interrupts
    csr_mstatus_i = '0;
    csr_mie_i     = 64'h888;
    irq_i         = 3'b111;
    #1;
    check("masked_hold", XLEN'(trap_hold_o), 64'd0);
    fire();
    check("masked_valid", XLEN'(trap_valid_o), 64'd0);
    step();

    // held event retriggers with three-cycle spacing
    csr_mstatus_i = 64'h8;
    expt_info_i   = 4'b0100;
    step();
    step();
    check("b2b_first",  XLEN'(trap_valid_o), 64'd1);
    step();
    check("b2b_gap1",   XLEN'(trap_valid_o), 64'd0);
    step();
    check("b2b_gap2",   XLEN'(trap_valid_o), 64'd0);
    step();
    check("b2b_second", XLEN'(trap_valid_o), 64'd1);
    clear_events();
    step();
    step();

    // reset while in TRAP
    expt_info_i = 4'b0100;
    step();
    clear_events();
    check("rtrap_hold_before", XLEN'(trap_hold_o), 64'd1);
    rst_n = 1'b0;
    #1;
    check("rtrap_hold",  XLEN'(trap_hold_o),  64'd0);
    check("rtrap_valid", XLEN'(trap_valid_o), 64'd0);
    #2;
    rst_n = 1'b1;
    step();
    step();
    check("rtrap_valid_after", XLEN'(trap_valid_o), 64'd0);
    check_all_wen("rtrap_after", 1'b0);

    // reset while write strobes are presented
    expt_info_i = 4'b1000;
    inst_i      = 32'h1357_9BDF;
    fire();
    check("rwen_valid_before", XLEN'(trap_valid_o), 64'd1);
    rst_n = 1'b0;
    #1;
    check("rwen_valid",  XLEN'(trap_valid_o), 64'd0);
    check("rwen_mcause", mcause_wdata_o,      64'd0);
    check("rwen_mtval",  mtval_wdata_o,       64'd0);
    check("rwen_addr",   trap_addr_o,         64'd0);
    check_all_wen("rwen", 1'b0);
    #2;
    rst_n = 1'b1;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
